// File: rtl/icache_pkg.sv
// Shared constants, state encodings and the PC split helper for the instruction cache.
package icache_pkg;

  localparam int IDX_W  = 8;
  localparam int ADDR_W = 32;
  localparam int TAG_W  = ADDR_W - IDX_W - 2;
  localparam int LINES  = 1 << IDX_W;

  // Controller states, kept as plain constants so older code can share them.
  localparam logic [1:0] IC_IDLE  = 2'd0;
  localparam logic [1:0] IC_MISS  = 2'd1;
  localparam logic [1:0] IC_DRAIN = 2'd2;

  // Word address split into tag (upper) and line index (lower).
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
  } pc_split_t;

  // Takes the word address (byte offset already dropped).
  function automatic pc_split_t split_word_addr(input logic [ADDR_W-3:0] word_addr);
    pc_split_t s;
    s = word_addr;
    return s;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Line storage: valid bits, tags and data words with combinational read
// by index and a single synchronous write port. Only the valid bits are reset.
module icache_array
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output logic [31:0]      rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  logic [31:0]      wdata
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      // Each valid bit clears on reset and sets when its line is filled.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
        end else if (we && (widx == IDX_W'(gi))) begin
          valid_q[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag and data storage is not reset; the valid bit guards stale contents.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= wdata;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_mem[ridx];
  assign rdata  = data_mem[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits answer one cycle
// after acceptance; misses hold a word request to the memory controller until
// it answers, fill the line, return the word, then idle mc_req for one cycle.
module icache
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_ins_ok,
  output logic [31:0]       if_ins,
  output logic              mc_req,
  output logic [ADDR_W-1:0] mc_addr,
  input  logic              mc_ok,
  input  logic [31:0]       mc_data
);

  logic [1:0]        state_q,     state_d;
  logic              if_ins_ok_q, if_ins_ok_d;
  logic [31:0]       if_ins_q,    if_ins_d;
  logic              mc_req_q,    mc_req_d;
  logic [ADDR_W-1:0] mc_addr_q,   mc_addr_d;

  pc_split_t fetch_split;
  pc_split_t fill_split;
  logic      line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [31:0]      line_data;
  logic      hit;
  logic      fill_we;

  // Byte-offset bits are ignored by design.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{if_pc[1:0], mc_addr_q[1:0]};

  // During a miss mc_addr_q doubles as the latched fetch address.
  assign fetch_split = split_word_addr(if_pc[ADDR_W-1:2]);
  assign fill_split  = split_word_addr(mc_addr_q[ADDR_W-1:2]);

  assign hit     = line_valid && (line_tag == fetch_split.tag);
  assign fill_we = rdy && (state_q == IC_MISS) && mc_ok && !clear;

  icache_array u_array (
    .clk    (clk),
    .rst    (rst),
    .ridx   (fetch_split.idx),
    .rvalid (line_valid),
    .rtag   (line_tag),
    .rdata  (line_data),
    .we     (fill_we),
    .widx   (fill_split.idx),
    .wtag   (fill_split.tag),
    .wdata  (mc_data)
  );

  // Next-state logic; with rdy low everything holds.
  always_comb begin
    state_d     = state_q;
    if_ins_ok_d = if_ins_ok_q;
    if_ins_d    = if_ins_q;
    mc_req_d    = mc_req_q;
    mc_addr_d   = mc_addr_q;
    if (rdy) begin
      if_ins_ok_d = 1'b0;
      case (state_q)
        IC_IDLE: begin
          // The !if_ins_ok_q term stops a held request from being answered twice.
          if (if_req && !clear && !if_ins_ok_q) begin
            if (hit) begin
              if_ins_d    = line_data;
              if_ins_ok_d = 1'b1;
            end else begin
              mc_req_d  = 1'b1;
              mc_addr_d = {if_pc[ADDR_W-1:2], 2'b00};
              state_d   = IC_MISS;
            end
          end
        end
        IC_MISS: begin
          if (clear) begin
            mc_req_d = 1'b0;
            state_d  = IC_DRAIN;
          end else if (mc_ok) begin
            if_ins_d    = mc_data;
            if_ins_ok_d = 1'b1;
            mc_req_d    = 1'b0;
            state_d     = IC_DRAIN;
          end
        end
        IC_DRAIN: begin
          state_d = IC_IDLE;
        end
        default: begin
          mc_req_d = 1'b0;
          state_d  = IC_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IC_IDLE;
      if_ins_ok_q <= 1'b0;
      if_ins_q    <= 32'd0;
      mc_req_q    <= 1'b0;
      mc_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      if_ins_ok_q <= if_ins_ok_d;
      if_ins_q    <= if_ins_d;
      mc_req_q    <= mc_req_d;
      mc_addr_q   <= mc_addr_d;
    end
  end

  assign if_ins_ok = if_ins_ok_q;
  assign if_ins    = if_ins_q;
  assign mc_req    = mc_req_q;
  assign mc_addr   = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with a transaction-level reference model
// checked against every output on every cycle.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_ins_ok;
  logic [31:0] if_ins;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_ok;
  logic [31:0] mc_data;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  icache dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clear     (clear),
    .if_req    (if_req),
    .if_pc     (if_pc),
    .if_ins_ok (if_ins_ok),
    .if_ins    (if_ins),
    .mc_req    (mc_req),
    .mc_addr   (mc_addr),
    .mc_ok     (mc_ok),
    .mc_data   (mc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the cache as a map from line index to the word
  // address it holds and its data, plus the expected output values.
  bit [29:0]   m_word [int];
  logic [31:0] m_data [int];
  bit          m_waiting;   // word request outstanding
  bit          m_draining;  // one quiet cycle after a request ends
  bit          m_ok;
  logic [31:0] m_ins;
  bit          m_req;
  logic [31:0] m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  function automatic void model_step();
    int  idx;
    bit  was_ok;
    if (rst) begin
      m_word.delete();
      m_data.delete();
      m_waiting = 0; m_draining = 0;
      m_ok = 0; m_ins = 0; m_req = 0; m_addr = 0;
      return;
    end
    if (!rdy) return;
    was_ok = m_ok;
    m_ok = 0;
    if (m_draining) begin
      m_draining = 0;
    end else if (m_waiting) begin
      if (clear) begin
        m_waiting = 0; m_req = 0; m_draining = 1;
      end else if (mc_ok) begin
        idx = int'(m_addr[9:2]);
        m_word[idx] = m_addr[31:2];
        m_data[idx] = mc_data;
        m_ins = mc_data; m_ok = 1;
        m_waiting = 0; m_req = 0; m_draining = 1;
      end
    end else if (if_req && !clear && !was_ok) begin
      idx = int'(if_pc[9:2]);
      if (m_word.exists(idx) && m_word[idx] == if_pc[31:2]) begin
        m_ins = m_data[idx]; m_ok = 1;
      end else begin
        m_req = 1; m_addr = {if_pc[31:2], 2'b00}; m_waiting = 1;
      end
    end
  endfunction

  // One clock: advance the model on the inputs the DUT sees, then compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cycle++;
    check("if_ins_ok", {31'd0, if_ins_ok}, {31'd0, m_ok});
    check("if_ins",    if_ins,             m_ins);
    check("mc_req",    {31'd0, mc_req},    {31'd0, m_req});
    check("mc_addr",   mc_addr,            m_addr);
  endtask

  // Full fetch: hold the request, answer a miss after lat extra cycles,
  // then release the request and let one cycle pass.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] fill, input int lat,
                       output bit missed, output logic [31:0] ins);
    bit got;
    missed = 0; got = 0; ins = '0;
    if_req = 1; if_pc = pc;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      mc_ok = 0;
      if (if_ins_ok) begin
        got = 1; ins = if_ins;
      end else if (mc_req && !missed) begin
        missed = 1;
        check("miss_addr", mc_addr, {pc[31:2], 2'b00});
        repeat (lat) tick();
        mc_ok = 1; mc_data = fill;
      end
    end
    mc_ok = 0;
    if (!got) check("fetch_timeout", 32'd0, 32'd1);
    $display("[TB] fetch pc=%h ins=%h miss=%0d cycle=%0d", pc, ins, missed, cycle);
    if_req = 0;
    tick();
  endtask

  initial begin
    bit          missed;
    logic [31:0] ins;
    int          pulses;

    rst = 1; rdy = 1; clear = 0; if_req = 0; if_pc = 0; mc_ok = 0; mc_data = 0;
    tick(); tick();
    check("rst_ok",   {31'd0, if_ins_ok}, 32'd0);
    check("rst_ins",  if_ins, 32'd0);
    check("rst_req",  {31'd0, mc_req}, 32'd0);
    check("rst_addr", mc_addr, 32'd0);
    rst = 0;
    tick();

    // 1: cold miss at 0x0, answered six cycles after the request appears.
    fetch(32'h0, 32'h00000513, 5, missed, ins);
    check("t1_missed", {31'd0, missed}, 32'd1);
    check("t1_ins", ins, 32'h00000513);
    check("t1_drain_req", {31'd0, mc_req}, 32'd0);

    // 2: same PC now hits, no memory request.
    fetch(32'h0, 32'hxxxxxxxx, 0, missed, ins);
    check("t2_missed", {31'd0, missed}, 32'd0);
    check("t2_ins", ins, 32'h00000513);

    // 3: 0x400 maps to line 0 with a new tag and evicts 0x0.
    fetch(32'h400, 32'h00100093, 2, missed, ins);
    check("t3_missed", {31'd0, missed}, 32'd1);
    check("t3_ins", ins, 32'h00100093);
    fetch(32'h0, 32'h00000513, 1, missed, ins);
    check("t3_refetch_missed", {31'd0, missed}, 32'd1);
    check("t3_refetch_ins", ins, 32'h00000513);

    // Held hit request answers every other cycle; stray mc_ok in IDLE ignored.
    if_req = 1; if_pc = 32'h0; pulses = 0;
    for (int i = 0; i < 4; i++) begin
      mc_ok = (i == 1); mc_data = 32'hbad0bad0;
      tick();
      if (if_ins_ok) pulses++;
    end
    mc_ok = 0; if_req = 0;
    tick();
    check("hit_pulses", pulses, 32'd2);
    check("hit_ins", if_ins, 32'h00000513);

    // 4: clear two cycles into a miss, with mc_ok in the same cycle.
    if_req = 1; if_pc = 32'h8;
    tick(); tick();
    clear = 1; mc_ok = 1; mc_data = 32'hdeadbeef; if_req = 0;
    tick();
    check("t4_req", {31'd0, mc_req}, 32'd0);
    check("t4_ok", {31'd0, if_ins_ok}, 32'd0);
    clear = 0; mc_ok = 0;
    tick(); tick();
    check("t4_ins_kept", if_ins, 32'h00000513);
    fetch(32'h8, 32'h00200113, 3, missed, ins);
    check("t4_missed", {31'd0, missed}, 32'd1);
    check("t4_ins", ins, 32'h00200113);

    // 5: freeze for three cycles mid-miss; an mc_ok while frozen is ignored.
    if_req = 1; if_pc = 32'hC;
    tick(); tick();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      mc_ok = (i == 1); mc_data = 32'h11111111;
      tick();
      check("t5_req", {31'd0, mc_req}, 32'd1);
      check("t5_addr", mc_addr, 32'hC);
      check("t5_ok", {31'd0, if_ins_ok}, 32'd0);
    end
    rdy = 1; mc_ok = 0;
    tick();
    check("t5_resume_req", {31'd0, mc_req}, 32'd1);
    mc_ok = 1; mc_data = 32'h00300193;
    tick();
    mc_ok = 0; if_req = 0;
    check("t5_ok_done", {31'd0, if_ins_ok}, 32'd1);
    check("t5_ins", if_ins, 32'h00300193);
    tick(); tick();

    // 6: reset mid-miss discards the request and all lines.
    if_req = 1; if_pc = 32'h10;
    tick(); tick();
    rst = 1; if_req = 0;
    tick();
    check("t6_ok", {31'd0, if_ins_ok}, 32'd0);
    check("t6_ins", if_ins, 32'd0);
    check("t6_req", {31'd0, mc_req}, 32'd0);
    check("t6_addr", mc_addr, 32'd0);
    rst = 0;
    tick();
    fetch(32'h0, 32'h00000513, 0, missed, ins);
    check("t6_missed", {31'd0, missed}, 32'd1);
    check("t6_ins", ins, 32'h00000513);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
